// File: rtl/mem_port_arbiter.sv
// Two-requester (IF / DM) round-robin arbiter for a single stb/ack memory port.
// Optional watchdog abort of hung transactions is enabled with `define ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_if_stb,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_ack,
  output logic [DATA_W-1:0]   o_if_data,
  output logic                o_if_err,
  input  logic                i_dm_stb,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic                i_dm_we,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  input  logic [DATA_W/8-1:0] i_dm_sel,
  output logic                o_dm_ack,
  output logic [DATA_W-1:0]   o_dm_data,
  output logic                o_dm_err,
  output logic                o_mem_stb,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_we,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_sel,
  input  logic                i_mem_ack,
  input  logic [DATA_W-1:0]   i_mem_data
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t state;
  owner_t owner;
  owner_t last_grant;

  logic              grant_dm;
  logic              timeout_hit;
  logic              done;
  logic [DATA_W-1:0] resp_data;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;

  assign timeout_hit = (wait_cnt == WAIT_LIMIT) && !i_mem_ack;
`else
  assign timeout_hit = 1'b0;
`endif

  // DM wins when alone, or when both request and IF was granted last.
  always_comb begin
    grant_dm = 1'b0;
    if (i_dm_stb && (!i_if_stb || last_grant == OWN_IF))
      grant_dm = 1'b1;
  end

  assign done      = i_mem_ack || timeout_hit;
  assign resp_data = (timeout_hit || o_mem_we) ? '0 : i_mem_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      owner       <= OWN_IF;
      last_grant  <= OWN_DM;
      o_if_ack    <= 1'b0;
      o_if_data   <= '0;
      o_if_err    <= 1'b0;
      o_dm_ack    <= 1'b0;
      o_dm_data   <= '0;
      o_dm_err    <= 1'b0;
      o_mem_stb   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_mem_wdata <= '0;
      o_mem_sel   <= '0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_if_stb || i_dm_stb) begin
            o_mem_stb <= 1'b1;
            state     <= S_BUSY;
`ifdef ARB_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
            if (grant_dm) begin
              owner       <= OWN_DM;
              last_grant  <= OWN_DM;
              o_mem_addr  <= i_dm_addr;
              o_mem_we    <= i_dm_we;
              o_mem_wdata <= i_dm_wdata;
              o_mem_sel   <= i_dm_sel;
            end else begin
              owner       <= OWN_IF;
              last_grant  <= OWN_IF;
              o_mem_addr  <= i_if_addr;
              o_mem_we    <= 1'b0;
              o_mem_wdata <= '0;
              o_mem_sel   <= '1;
            end
          end
        end
        S_BUSY: begin
          if (done) begin
            o_mem_stb   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= '0;
            o_mem_sel   <= '0;
            state       <= S_RESP;
            if (owner == OWN_DM) begin
              o_dm_ack  <= 1'b1;
              o_dm_data <= resp_data;
              o_dm_err  <= timeout_hit;
            end else begin
              o_if_ack  <= 1'b1;
              o_if_data <= resp_data;
              o_if_err  <= timeout_hit;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        S_RESP: begin
          o_if_ack  <= 1'b0;
          o_if_data <= '0;
          o_if_err  <= 1'b0;
          o_dm_ack  <= 1'b0;
          o_dm_data <= '0;
          o_dm_err  <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a configurable
// same-cycle / delayed / silent memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_if_stb;
  logic [31:0] i_if_addr;
  logic        o_if_ack;
  logic [31:0] o_if_data;
  logic        o_if_err;
  logic        i_dm_stb;
  logic [31:0] i_dm_addr;
  logic        i_dm_we;
  logic [31:0] i_dm_wdata;
  logic [3:0]  i_dm_sel;
  logic        o_dm_ack;
  logic [31:0] o_dm_data;
  logic        o_dm_err;
  logic        o_mem_stb;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_sel;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;

  logic        mem_auto;
  logic        mem_force;
  int          mem_delay;
  int          busy_cnt;
  logic [31:0] mem_rdata;

  int tests;
  int fails;
  int if_acks;
  int dm_acks;
  logic both_acks;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .i_if_stb(i_if_stb), .i_if_addr(i_if_addr),
    .o_if_ack(o_if_ack), .o_if_data(o_if_data), .o_if_err(o_if_err),
    .i_dm_stb(i_dm_stb), .i_dm_addr(i_dm_addr), .i_dm_we(i_dm_we),
    .i_dm_wdata(i_dm_wdata), .i_dm_sel(i_dm_sel),
    .o_dm_ack(o_dm_ack), .o_dm_data(o_dm_data), .o_dm_err(o_dm_err),
    .o_mem_stb(o_mem_stb), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
    .o_mem_wdata(o_mem_wdata), .o_mem_sel(o_mem_sel),
    .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data)
  );

  // Memory: acks after mem_delay cycles of o_mem_stb (0 = same cycle).
  always @(posedge clk) busy_cnt <= o_mem_stb ? busy_cnt + 1 : 0;
  assign i_mem_ack  = mem_force | (mem_auto & o_mem_stb & (busy_cnt >= mem_delay));
  assign i_mem_data = mem_rdata;

  always @(posedge clk) begin
    if (o_if_ack) if_acks <= if_acks + 1;
    if (o_dm_ack) dm_acks <= dm_acks + 1;
    if (o_if_ack && o_dm_ack) both_acks <= 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    tests++;
    if ({o_mem_stb, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_sel} !== 70'd0) begin
      fails++;
      $display("FAIL reset_mem: got stb=%b addr=%h we=%b wdata=%h sel=%h, expected all 0",
               o_mem_stb, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_sel);
    end
    tests++;
    if ({o_if_ack, o_if_data, o_if_err, o_dm_ack, o_dm_data, o_dm_err} !== 68'd0) begin
      fails++;
      $display("FAIL reset_resp: got if_ack=%b if_data=%h dm_ack=%b dm_data=%h, expected all 0",
               o_if_ack, o_if_data, o_dm_ack, o_dm_data);
    end
  endtask

  task automatic test_if_read;
    int base;
    base = if_acks;
    mem_auto = 1'b1; mem_delay = 0; mem_rdata = 32'h00500093;
    i_if_addr = 32'h00000010; i_if_stb = 1'b1;
    step(1);
    tests++;
    if ({o_mem_stb, o_mem_addr, o_mem_sel, o_mem_we, o_if_ack} !== {1'b1, 32'h10, 4'hF, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL if_grant: got stb=%b addr=%h sel=%h we=%b ack=%b, expected 1 00000010 f 0 0",
               o_mem_stb, o_mem_addr, o_mem_sel, o_mem_we, o_if_ack);
    end
    step(1);
    tests++;
    if ({o_if_ack, o_if_data, o_if_err, o_mem_stb} !== {1'b1, 32'h00500093, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL if_ack: got ack=%b data=%h err=%b stb=%b, expected 1 00500093 0 0",
               o_if_ack, o_if_data, o_if_err, o_mem_stb);
    end
    // stb held through RESP; the arbiter must not re-issue
    step(1);
    tests++;
    if (o_if_ack !== 1'b0) begin
      fails++;
      $display("FAIL if_ack_pulse: got ack=%b, expected 0", o_if_ack);
    end
    i_if_stb = 1'b0;
    step(3);
    tests++;
    if (o_mem_stb !== 1'b0 || if_acks - base != 1) begin
      fails++;
      $display("FAIL if_single_ack: got stb=%b acks=%0d, expected 0 1", o_mem_stb, if_acks - base);
    end
  endtask

  task automatic test_alternate;
    string order;
    order = "";
    mem_auto = 1'b1; mem_delay = 0; mem_rdata = 32'h11112222;
    i_if_addr  = 32'h00000100;
    i_dm_addr  = 32'h00000020; i_dm_we = 1'b1;
    i_dm_wdata = 32'hDEADBEEF; i_dm_sel = 4'h3;
    i_if_stb = 1'b1; i_dm_stb = 1'b1;
    for (int c = 0; c < 20 && order.len() < 4; c++) begin
      step(1);
      if (o_mem_stb && o_mem_we) begin
        tests++;
        if ({o_mem_addr, o_mem_wdata, o_mem_sel} !== {32'h20, 32'hDEADBEEF, 4'h3}) begin
          fails++;
          $display("FAIL dm_write_port: got addr=%h wdata=%h sel=%h, expected 00000020 deadbeef 3",
                   o_mem_addr, o_mem_wdata, o_mem_sel);
        end
      end
      if (!i_if_stb) i_if_stb = 1'b1;
      if (!i_dm_stb) i_dm_stb = 1'b1;
      if (o_if_ack) begin order = {order, "I"}; i_if_stb = 1'b0; end
      if (o_dm_ack) begin
        order = {order, "D"}; i_dm_stb = 1'b0;
        tests++;
        if (o_dm_data !== 32'h0) begin
          fails++;
          $display("FAIL dm_write_data: got %h, expected 00000000", o_dm_data);
        end
      end
    end
    i_if_stb = 1'b0; i_dm_stb = 1'b0;
    tests++;
    if (order != "IDID") begin
      fails++;
      $display("FAIL alternate_order: got '%s', expected 'IDID'", order);
    end
    step(3);
  endtask

  task automatic test_delayed_read;
    int if_base;
    if_base = if_acks;
    mem_auto = 1'b1; mem_delay = 5; mem_rdata = 32'h12345678;
    i_dm_addr = 32'h00000044; i_dm_we = 1'b0; i_dm_wdata = 32'h0; i_dm_sel = 4'hF;
    i_dm_stb = 1'b1;
    step(1);
    for (int c = 0; c < 6; c++) begin
      tests++;
      if ({o_mem_stb, o_mem_addr, o_mem_we, o_mem_sel, o_dm_ack} !== {1'b1, 32'h44, 1'b0, 4'hF, 1'b0}) begin
        fails++;
        $display("FAIL delayed_hold[%0d]: got stb=%b addr=%h we=%b sel=%h ack=%b, expected 1 00000044 0 f 0",
                 c, o_mem_stb, o_mem_addr, o_mem_we, o_mem_sel, o_dm_ack);
      end
      step(1);
    end
    tests++;
    if ({o_dm_ack, o_dm_data, o_dm_err} !== {1'b1, 32'h12345678, 1'b0}) begin
      fails++;
      $display("FAIL delayed_ack: got ack=%b data=%h err=%b, expected 1 12345678 0",
               o_dm_ack, o_dm_data, o_dm_err);
    end
    i_dm_stb = 1'b0;
    step(3);
    tests++;
    if (if_acks != if_base) begin
      fails++;
      $display("FAIL delayed_no_if_ack: got %0d if acks, expected 0", if_acks - if_base);
    end
    mem_delay = 0;
  endtask

  task automatic test_reset_busy;
    int if_base;
    int dm_base;
    mem_auto = 1'b0;
    i_if_addr = 32'h00000080; i_if_stb = 1'b1;
    step(3);
    rst = 1'b1; i_if_stb = 1'b0;
    if_base = if_acks; dm_base = dm_acks;
    step(1);
    rst = 1'b0;
    test_reset();
    step(4);
    tests++;
    if (if_acks != if_base || dm_acks != dm_base || o_mem_stb !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy_drop: got if_acks=%0d dm_acks=%0d stb=%b, expected 0 0 0",
               if_acks - if_base, dm_acks - dm_base, o_mem_stb);
    end
    mem_auto = 1'b1; mem_rdata = 32'hCAFEF00D;
    i_if_addr = 32'h00000084; i_if_stb = 1'b1;
    step(2);
    tests++;
    if ({o_if_ack, o_if_data} !== {1'b1, 32'hCAFEF00D}) begin
      fails++;
      $display("FAIL reset_recover: got ack=%b data=%h, expected 1 cafef00d", o_if_ack, o_if_data);
    end
    i_if_stb = 1'b0;
    step(3);
  endtask

  task automatic test_spurious_ack;
    int if_base;
    int dm_base;
    if_base = if_acks; dm_base = dm_acks;
    mem_force = 1'b1;
    step(3);
    mem_force = 1'b0;
    step(2);
    tests++;
    if (if_acks != if_base || dm_acks != dm_base || o_mem_stb !== 1'b0) begin
      fails++;
      $display("FAIL spurious_ack: got if_acks=%0d dm_acks=%0d stb=%b, expected 0 0 0",
               if_acks - if_base, dm_acks - dm_base, o_mem_stb);
    end
  endtask

  task automatic test_timeout;
    mem_auto = 1'b0;
    i_dm_addr = 32'h00000200; i_dm_we = 1'b0; i_dm_sel = 4'hF;
    i_dm_stb = 1'b1;
    step(1);
`ifdef ARB_TIMEOUT_EN
    begin
      int k;
      k = 0;
      while (!o_dm_ack && k < 40) begin
        step(1);
        k++;
      end
      tests++;
      if (k != 16 || {o_dm_err, o_dm_data, o_mem_stb} !== {1'b1, 32'h0, 1'b0}) begin
        fails++;
        $display("FAIL timeout_abort: got cycles=%0d err=%b data=%h stb=%b, expected 16 1 00000000 0",
                 k, o_dm_err, o_dm_data, o_mem_stb);
      end
      i_dm_stb = 1'b0;
      step(3);
    end
`else
    step(99);
    tests++;
    if (o_mem_stb !== 1'b1 || o_dm_ack !== 1'b0 || o_mem_addr !== 32'h200) begin
      fails++;
      $display("FAIL no_timeout_wait: got stb=%b ack=%b addr=%h, expected 1 0 00000200",
               o_mem_stb, o_dm_ack, o_mem_addr);
    end
    rst = 1'b1; i_dm_stb = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);
`endif
  endtask

  task automatic test_exclusive_acks;
    tests++;
    if (both_acks !== 1'b0) begin
      fails++;
      $display("FAIL exclusive_acks: got both-high=%b, expected 0", both_acks);
    end
  endtask

  initial begin
    tests = 0; fails = 0; if_acks = 0; dm_acks = 0; both_acks = 1'b0;
    rst = 1'b1;
    i_if_stb = 1'b0; i_if_addr = '0;
    i_dm_stb = 1'b0; i_dm_addr = '0; i_dm_we = 1'b0; i_dm_wdata = '0; i_dm_sel = '0;
    mem_auto = 1'b0; mem_force = 1'b0; mem_delay = 0; mem_rdata = '0;
    step(2);
    rst = 1'b0;
    test_reset();
    test_if_read();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    test_alternate();
    test_delayed_read();
    test_reset_busy();
    test_spurious_ack();
    test_timeout();
    test_exclusive_acks();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
